// File: rtl/gest_interrup_n_if.sv
// Interrupt controller bus: request/mask/strobe inputs from the CPU side and
// take/vector/status outputs back to the PC mux and UC.
interface gest_interrup_n_if #(
  parameter int N_INT = 4,
  parameter int PC_W  = 10,
  parameter int ID_W  = 4
);
  logic [N_INT-1:0] int_req;
  logic             mask_we;
  logic [N_INT-1:0] mask_wdata;
  logic             int_inhibit;
  logic             fin_interrup;
  logic             int_take;
  logic [PC_W-1:0]  vector_addr;
  logic [ID_W-1:0]  int_id;
  logic             int_active;
  logic [N_INT-1:0] pending;
  logic [N_INT-1:0] in_service;
  logic [N_INT-1:0] mask;

  modport master (
    output int_req, mask_we, mask_wdata, int_inhibit, fin_interrup,
    input  int_take, vector_addr, int_id, int_active, pending, in_service, mask
  );

  modport slave (
    input  int_req, mask_we, mask_wdata, int_inhibit, fin_interrup,
    output int_take, vector_addr, int_id, int_active, pending, in_service, mask
  );
endinterface

// File: rtl/gest_interrup_n.sv
// N-channel fixed-priority interrupt controller (channel 0 highest) with edge
// capture, mask, in-service tracking. Define INT_NEST_EN to allow preemption.
module gest_interrup_n #(
  parameter int N_INT      = 4,
  parameter int PC_W       = 10,
  parameter int VEC_BASE   = 1000,
  parameter int VEC_STRIDE = 4,
  parameter int ID_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  gest_interrup_n_if.slave bus
);
  localparam int IDX_W = (N_INT > 1) ? $clog2(N_INT) : 1;

  logic [N_INT-1:0] req_prev_q, req_prev_d;
  logic [N_INT-1:0] pending_q, pending_d;
  logic [N_INT-1:0] in_service_q, in_service_d;
  logic [N_INT-1:0] mask_q, mask_d;
  logic             int_take_q, int_take_d;
  logic [PC_W-1:0]  vector_addr_q, vector_addr_d;
  logic [ID_W-1:0]  int_id_q, int_id_d;

  logic [N_INT-1:0] rise, elig;
  logic             win_vld, isv_vld, fin_clr, take_ok, take;
  logic [IDX_W-1:0] win_idx, isv_idx;

  // Priority encoders: lowest-index eligible request and lowest-index ISR in service.
  always_comb begin
    rise    = bus.int_req & ~req_prev_q;
    elig    = pending_q & mask_q;
    win_vld = |elig;
    isv_vld = |in_service_q;
    win_idx = '0;
    isv_idx = '0;
    for (int i = N_INT - 1; i >= 0; i--) begin
      if (elig[i])         win_idx = IDX_W'(i);
      if (in_service_q[i]) isv_idx = IDX_W'(i);
    end
  end

  // A retiring ISR takes precedence; the take is re-evaluated next cycle.
  always_comb begin
    fin_clr = bus.fin_interrup & isv_vld;
`ifdef INT_NEST_EN
    take_ok = !isv_vld || (win_idx < isv_idx);
`else
    take_ok = !isv_vld;
`endif
    take = win_vld & ~bus.int_inhibit & ~int_take_q & take_ok & ~fin_clr;
  end

  always_comb begin
    req_prev_d    = bus.int_req;
    mask_d        = bus.mask_we ? bus.mask_wdata : mask_q;
    int_take_d    = take;
    pending_d     = pending_q;
    in_service_d  = in_service_q;
    vector_addr_d = vector_addr_q;
    int_id_d      = int_id_q;
    if (fin_clr) in_service_d[isv_idx] = 1'b0;
    if (take) begin
      pending_d[win_idx]    = 1'b0;
      in_service_d[win_idx] = 1'b1;
      int_id_d              = ID_W'(win_idx);
      vector_addr_d         = PC_W'(VEC_BASE + int'(win_idx) * VEC_STRIDE);
    end
    // A new edge on the winner in the take cycle keeps it pending.
    pending_d = pending_d | rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_prev_q    <= '0;
      pending_q     <= '0;
      in_service_q  <= '0;
      mask_q        <= '1;
      int_take_q    <= 1'b0;
      vector_addr_q <= PC_W'(VEC_BASE);
      int_id_q      <= '0;
    end else begin
      req_prev_q    <= req_prev_d;
      pending_q     <= pending_d;
      in_service_q  <= in_service_d;
      mask_q        <= mask_d;
      int_take_q    <= int_take_d;
      vector_addr_q <= vector_addr_d;
      int_id_q      <= int_id_d;
    end
  end

  assign bus.int_take    = int_take_q;
  assign bus.vector_addr = vector_addr_q;
  assign bus.int_id      = int_id_q;
  assign bus.int_active  = |in_service_q;
  assign bus.pending     = pending_q;
  assign bus.in_service  = in_service_q;
  assign bus.mask        = mask_q;
endmodule

// File: tb/tb_gest_interrup_n.sv
// Self-checking bench for gest_interrup_n: directed scenarios plus random
// stimulus compared against a cycle-level behavioural model.
module tb_gest_interrup_n;
  localparam int N = 4;
`ifdef INT_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gest_interrup_n_if #(.N_INT(N), .PC_W(10), .ID_W(4)) bus ();
  gest_interrup_n #(.N_INT(N), .PC_W(10), .VEC_BASE(1000), .VEC_STRIDE(4), .ID_W(4))
    dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;

  logic [3:0] m_prev, m_pend, m_mask, m_isv, m_id;
  logic       m_take;
  logic [9:0] m_vec;

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_mask = 4'hF; m_isv = '0;
    m_take = 1'b0; m_id = '0; m_vec = 10'd1000;
  endtask

  // Drive one cycle of inputs, advance past the edge, update the model.
  task automatic step(input logic [3:0] req, input logic mwe, input logic [3:0] mwd,
                      input logic inh, input logic fin);
    logic [3:0] rise;
    int w, s;
    bit fin_eff, tk;
    bus.int_req = req; bus.mask_we = mwe; bus.mask_wdata = mwd;
    bus.int_inhibit = inh; bus.fin_interrup = fin;
    rise    = req & ~m_prev;
    w       = lowest(m_pend & m_mask);
    s       = lowest(m_isv);
    fin_eff = fin && (s >= 0);
    tk      = (w >= 0) && !inh && !m_take && ((s < 0) || (NEST && w < s)) && !fin_eff;
    @(posedge clk);
    m_prev = req;
    if (mwe) m_mask = mwd;
    if (fin_eff) m_isv[s] = 1'b0;
    if (tk) begin
      m_pend[w] = 1'b0;
      m_isv[w]  = 1'b1;
      m_id      = 4'(w);
      m_vec     = 10'((1000 + 4 * w) % 1024);
    end
    m_pend = m_pend | rise;
    m_take = tk;
    #1;
  endtask

  task automatic test_reset();
    bus.int_req = '0; bus.mask_we = 1'b0; bus.mask_wdata = '0;
    bus.int_inhibit = 1'b0; bus.fin_interrup = 1'b0;
    reset = 1'b0;
    #12;
    n_cmp++; if (bus.int_take !== 1'b0) begin n_fail++; $display("FAIL reset_take got %b want 0", bus.int_take); end
    n_cmp++; if (bus.vector_addr !== 10'd1000) begin n_fail++; $display("FAIL reset_vec got %0d want 1000", bus.vector_addr); end
    n_cmp++; if (bus.int_id !== 4'd0) begin n_fail++; $display("FAIL reset_id got %0d want 0", bus.int_id); end
    n_cmp++; if (bus.int_active !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b want 0", bus.int_active); end
    n_cmp++; if (bus.pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending got %b want 0000", bus.pending); end
    n_cmp++; if (bus.in_service !== 4'b0000) begin n_fail++; $display("FAIL reset_isv got %b want 0000", bus.in_service); end
    n_cmp++; if (bus.mask !== 4'b1111) begin n_fail++; $display("FAIL reset_mask got %b want 1111", bus.mask); end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    step(4'b0000, 0, 0, 0, 0);
    step(4'b0100, 0, 0, 0, 0);
    n_cmp++; if (bus.pending !== 4'b0100 || bus.int_take !== 1'b0) begin n_fail++; $display("FAIL single_capture got pend=%b take=%b want 0100/0", bus.pending, bus.int_take); end
    step(4'b0100, 0, 0, 0, 0);
    n_cmp++; if (bus.int_take !== 1'b1) begin n_fail++; $display("FAIL single_take got %b want 1", bus.int_take); end
    n_cmp++; if (bus.int_id !== 4'd2 || bus.vector_addr !== 10'd1008) begin n_fail++; $display("FAIL single_vec got id=%0d vec=%0d want 2/1008", bus.int_id, bus.vector_addr); end
    n_cmp++; if (bus.in_service !== 4'b0100 || bus.pending !== 4'b0000 || bus.int_active !== 1'b1) begin n_fail++; $display("FAIL single_state got isv=%b pend=%b act=%b want 0100/0000/1", bus.in_service, bus.pending, bus.int_active); end
    step(4'b0100, 0, 0, 0, 0);
    n_cmp++; if (bus.int_take !== 1'b0) begin n_fail++; $display("FAIL single_pulse got %b want 0", bus.int_take); end
    step(4'b0000, 0, 0, 0, 1);
    n_cmp++; if (bus.in_service !== 4'b0000 || bus.vector_addr !== 10'd1008) begin n_fail++; $display("FAIL single_fin got isv=%b vec=%0d want 0000/1008", bus.in_service, bus.vector_addr); end
  endtask

  task automatic test_simultaneous();
    step(4'b1010, 0, 0, 0, 0);
    n_cmp++; if (bus.pending !== 4'b1010) begin n_fail++; $display("FAIL simul_pending got %b want 1010", bus.pending); end
    step(4'b1010, 0, 0, 0, 0);
    n_cmp++; if (bus.int_take !== 1'b1 || bus.int_id !== 4'd1 || bus.vector_addr !== 10'd1004) begin n_fail++; $display("FAIL simul_first got take=%b id=%0d vec=%0d want 1/1/1004", bus.int_take, bus.int_id, bus.vector_addr); end
    for (int i = 0; i < 2; i++) begin
      step(4'b1010, 0, 0, 0, 0);
      n_cmp++; if (bus.int_take !== 1'b0 || bus.pending !== 4'b1000) begin n_fail++; $display("FAIL simul_wait got take=%b pend=%b want 0/1000", bus.int_take, bus.pending); end
    end
    step(4'b1010, 0, 0, 0, 1);
    n_cmp++; if (bus.int_take !== 1'b0 || bus.in_service !== 4'b0000) begin n_fail++; $display("FAIL simul_fin got take=%b isv=%b want 0/0000", bus.int_take, bus.in_service); end
    step(4'b1010, 0, 0, 0, 0);
    n_cmp++; if (bus.int_take !== 1'b1 || bus.int_id !== 4'd3 || bus.vector_addr !== 10'd1012 || bus.in_service !== 4'b1000) begin n_fail++; $display("FAIL simul_second got take=%b id=%0d vec=%0d isv=%b want 1/3/1012/1000", bus.int_take, bus.int_id, bus.vector_addr, bus.in_service); end
    step(4'b0000, 0, 0, 0, 1);
  endtask

  task automatic test_mask();
    step(4'b0000, 1, 4'b1110, 0, 0);
    n_cmp++; if (bus.mask !== 4'b1110) begin n_fail++; $display("FAIL mask_write got %b want 1110", bus.mask); end
    step(4'b0001, 0, 0, 0, 0);
    n_cmp++; if (bus.pending !== 4'b0001) begin n_fail++; $display("FAIL mask_pending got %b want 0001", bus.pending); end
    for (int i = 0; i < 2; i++) begin
      step(4'b0001, 0, 0, 0, 0);
      n_cmp++; if (bus.int_take !== 1'b0) begin n_fail++; $display("FAIL mask_blocked got %b want 0", bus.int_take); end
    end
    step(4'b0001, 1, 4'b1111, 0, 0);
    n_cmp++; if (bus.int_take !== 1'b0 || bus.mask !== 4'b1111) begin n_fail++; $display("FAIL mask_unmask got take=%b mask=%b want 0/1111", bus.int_take, bus.mask); end
    step(4'b0001, 0, 0, 0, 0);
    n_cmp++; if (bus.int_take !== 1'b1 || bus.int_id !== 4'd0 || bus.vector_addr !== 10'd1000) begin n_fail++; $display("FAIL mask_take got take=%b id=%0d vec=%0d want 1/0/1000", bus.int_take, bus.int_id, bus.vector_addr); end
    step(4'b0000, 0, 0, 0, 1);
  endtask

  task automatic test_inhibit();
    for (int i = 0; i < 5; i++) begin
      step(4'b0100, 0, 0, 1, 0);
      n_cmp++; if (bus.int_take !== 1'b0 || bus.pending !== 4'b0100) begin n_fail++; $display("FAIL inhibit_hold got take=%b pend=%b want 0/0100", bus.int_take, bus.pending); end
    end
    step(4'b0100, 0, 0, 0, 0);
    n_cmp++; if (bus.int_take !== 1'b1 || bus.int_id !== 4'd2) begin n_fail++; $display("FAIL inhibit_release got take=%b id=%0d want 1/2", bus.int_take, bus.int_id); end
    step(4'b0000, 0, 0, 0, 1);
  endtask

  task automatic test_preempt();
    logic [7:0] fins;
    step(4'b1000, 0, 0, 0, 0);
    step(4'b1000, 0, 0, 0, 0);
    n_cmp++; if (bus.in_service !== 4'b1000) begin n_fail++; $display("FAIL preempt_ch3 got isv=%b want 1000", bus.in_service); end
    fins = 8'b0101_0100;
    for (int i = 0; i < 8; i++) begin
      step(4'b1001, 0, 0, 0, fins[7-i]);
      n_cmp++; if (bus.int_take !== m_take || bus.in_service !== m_isv || bus.int_id !== m_id) begin n_fail++; $display("FAIL preempt_step%0d got take=%b isv=%b id=%0d want %b/%b/%0d", i, bus.int_take, bus.in_service, bus.int_id, m_take, m_isv, m_id); end
    end
    step(4'b0000, 0, 0, 0, 1);
    step(4'b0000, 0, 0, 0, 1);
  endtask

  task automatic test_reset_mid_isr();
    step(4'b0010, 0, 0, 0, 0);
    step(4'b0110, 0, 0, 0, 0);
    n_cmp++; if (bus.int_active !== 1'b1) begin n_fail++; $display("FAIL midreset_pre got active=%b want 1", bus.int_active); end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.in_service !== 4'b0000 || bus.pending !== 4'b0000 || bus.int_active !== 1'b0 || bus.int_take !== 1'b0 || bus.vector_addr !== 10'd1000) begin n_fail++; $display("FAIL midreset_clear got isv=%b pend=%b act=%b take=%b vec=%0d", bus.in_service, bus.pending, bus.int_active, bus.int_take, bus.vector_addr); end
    model_reset();
    #3;
    reset = 1'b1;
    step(4'b0000, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [29:0] got, exp;
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), ($urandom % 8) == 0, 4'($urandom), ($urandom % 4) == 0, ($urandom % 5) == 0);
      got = {bus.int_take, bus.vector_addr, bus.int_id, bus.int_active, bus.pending, bus.in_service, bus.mask};
      exp = {m_take, m_vec, m_id, |m_isv, m_pend, m_isv, m_mask};
      n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL random_cycle%0d got %h want %h", i, got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_mask();
    test_inhibit();
    test_preempt();
    test_reset_mid_isr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
